random_word_select: RTL and testbench
=====================================

// Module: random_word_select
// PURPOSE
//  Consumes the 13-bit pseudo-random word from the game LFSR and turns it into a uniform-ish
//  word/maze index in [0, NUM_WORDS-1] on a new-game request. Waits for a fresh LFSR value and
//  reduces it modulo NUM_WORDS with a bit-serial remainder. Optionally never repeats the previous
//  pick. Presents the index to the game controller over a valid/ready handshake.
// PARAMETERS
//  RND_W          13   width of rnd input
//  NUM_WORDS      20   number of selectable entries, >=1, <=2**RND_W
//  IDX_W           5   sel_index width, must be >= $clog2(NUM_WORDS) (min 1)
//  FRESH_TIMEOUT  31   max cycles to wait for rnd to change before using current value
//  AVOID_REPEAT    1   1: a pick equal to the previous pick is bumped by +1 mod NUM_WORDS
// PORTS
//  clock      in   1       clock, all state on posedge
//  reset      in   1       reset, synchronous, active-high
//  rnd        in   RND_W   LFSR output; changes at most once per 14 clocks
//  req        in   1       new-game request, sampled only in IDLE
//  busy       out  1       high in every state except IDLE
//  sel_valid  out  1       sel_index holds a valid pick
//  sel_ready  in   1       consumer accepts pick when sel_valid & sel_ready
//  sel_index  out  IDX_W   selected index, stable while sel_valid
// BEHAVIOUR
//  Reset: state IDLE; busy=0, sel_valid=0, sel_index=0; have_prev=0, prev_idx=0, counters 0.
//  Reset is honoured in any state and aborts any pick in progress; no partial result is emitted.
//  FSM: IDLE -> WAIT_FRESH -> REDUCE -> ADJUST -> PRESENT -> IDLE.
//  IDLE: on req=1, snap<=rnd, tmo<=0, go WAIT_FRESH. req in any other state is ignored (not queued).
//  WAIT_FRESH: if rnd!=snap or tmo==FRESH_TIMEOUT: shreg<=rnd, rem<=0, bitcnt<=0, go REDUCE
//    (the "capture edge" C). Else tmo<=tmo+1.
//  REDUCE: 13 cycles (RND_W), MSB first: t={rem,shreg[MSB]}; rem<= (t>=NUM_WORDS)? t-NUM_WORDS : t;
//    shreg<<=1. rem is IDX_W+1 bits; the comparison is unsigned. After bit RND_W-1, go ADJUST.
//  ADJUST: idx=rem; if AVOID_REPEAT && have_prev && NUM_WORDS>1 && idx==prev_idx then
//    idx = (idx==NUM_WORDS-1)? 0 : idx+1. sel_index<=idx, sel_valid<=1, go PRESENT.
//  Latency: sel_valid is high starting at edge C+RND_W+1 (C+14 at default).
//  PRESENT: sel_valid and sel_index held stable until sel_valid&sel_ready. On that edge:
//    sel_valid<=0, prev_idx<=sel_index, have_prev<=1, go IDLE. sel_index keeps its last value.
//  If req=1 on the handshake edge, it is ignored; a new req must be presented while in IDLE.
//  NUM_WORDS==1: sel_index is always 0 and AVOID_REPEAT has no effect.
//  rnd==0 is legal (index 0). rnd is never treated as X-tolerant; upstream guarantees a nonzero value.
// STRUCTURE
//  hangmaze_pkg: typedef enum logic [2:0] {IDLE,WAIT_FRESH,REDUCE,ADJUST,PRESENT} sel_state_t;
//    localparam LFSR_W=13 shared with the LFSR and the game controller.
//  Sub-module serial_mod_reducer (start, din[RND_W], done, rem[IDX_W]) implements the REDUCE loop.
//    Top keeps the FSM, fresh-value detection, repeat avoidance and handshake.
// TESTING (NUM_WORDS=20, default params)
//  1 Reset, req; rnd 0x00F -> 0x1234 (4660) -> sel_index=0, sel_valid 14 clocks after change.
//  2 Next req, rnd -> 0x1FFF (8191) -> sel_index=11 (8191 mod 20); hold sel_ready=0 for 10 clocks
//    -> sel_valid and index stay stable; accept -> IDLE, busy=0.
//  3 prev=11, rnd -> 31 (31 mod 20 = 11) -> sel_index=12 (repeat bump). With AVOID_REPEAT=0 -> 11.
//  4 prev=19, rnd -> 39 -> raw 19 -> sel_index=0 (wrap on bump).
//  5 Hold rnd=15 constant after req -> capture after 32 clocks (timeout) -> sel_index=15.
//  6 Assert reset mid-REDUCE -> next cycle IDLE, sel_valid=0, have_prev=0. Pulse req while in PRESENT
//    -> no second pick after the handshake.

Source files
------------

// File: rtl/hangmaze_pkg.sv
// Shared definitions for the hangmaze game datapath.
//   LFSR_W      : width of the game LFSR word, shared by the LFSR, the word
//                 selector and the game controller.
//   sel_state_t : state encoding of the random word selector FSM.
package hangmaze_pkg;

  localparam int LFSR_W = 13;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRESH,
    REDUCE,
    ADJUST,
    PRESENT
  } sel_state_t;

endpackage

// File: rtl/serial_mod_reducer.sv
// Bit-serial remainder unit: computes din mod NUM_WORDS, one input bit per
// clock, MSB first (restoring long division that keeps only the remainder).
// Ports:
//   clock  in   1      clock, posedge
//   reset  in   1      synchronous, active-high; clears the control state
//   start  in   1      load din and begin a reduction on this edge
//   din    in   RND_W  value to reduce
//   done   out  1      high during the cycle whose edge folds in the last bit
//   rem    out  IDX_W  remainder; final value is valid the cycle after done
module serial_mod_reducer #(
  parameter int RND_W     = 13,
  parameter int NUM_WORDS = 20,
  parameter int IDX_W     = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [RND_W-1:0] din,
  output logic             done,
  output logic [IDX_W-1:0] rem
);

  localparam int               CNT_W    = $clog2(RND_W + 1);
  localparam logic [IDX_W:0]   MODULUS  = (IDX_W + 1)'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RND_W - 1);

  logic             running;
  logic [CNT_W-1:0] bitcnt;
  logic [RND_W-1:0] shreg;
  logic [IDX_W-1:0] rem_q;

  // One division step. rem < NUM_WORDS <= 2**IDX_W, so the shifted trial
  // value always fits IDX_W+1 bits and at most one subtraction is needed.
  function automatic logic [IDX_W-1:0] reduce_step(input logic [IDX_W-1:0] r,
                                                   input logic             b);
    logic [IDX_W:0] trial;
    trial = {r, b};
    if (trial >= MODULUS) begin
      reduce_step = IDX_W'(trial - MODULUS);
    end else begin
      reduce_step = IDX_W'(trial);
    end
  endfunction

  // Combinational done lets the caller leave its wait state on the same edge
  // that consumes the last bit, so the remainder is ready one cycle later.
  assign done = running && (bitcnt == LAST_BIT);
  assign rem  = rem_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      running <= 1'b0;
      bitcnt  <= '0;
    end else if (start) begin
      running <= 1'b1;
      bitcnt  <= '0;
    end else if (running) begin
      bitcnt <= bitcnt + 1'b1;
      if (done) begin
        running <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (start) begin
      shreg <= din;
      rem_q <= '0;
    end else if (running) begin
      rem_q <= reduce_step(rem_q, shreg[RND_W-1]);
      shreg <= shreg << 1;
    end
  end

endmodule

// File: rtl/random_word_select.sv
// Random word/maze selector. On a new-game request it waits for a fresh LFSR
// word (or a timeout), reduces it modulo NUM_WORDS, optionally bumps a pick
// that equals the previous accepted pick, and presents the index on a
// valid/ready handshake.
// Ports:
//   clock      in   1      clock, all state on posedge
//   reset      in   1      synchronous, active-high; aborts any pick
//   rnd        in   RND_W  LFSR output
//   req        in   1      new-game request, only honoured in IDLE
//   busy       out  1      high in every state except IDLE
//   sel_valid  out  1      sel_index holds a valid pick
//   sel_ready  in   1      consumer accepts when sel_valid & sel_ready
//   sel_index  out  IDX_W  selected index, stable while sel_valid
module random_word_select
  import hangmaze_pkg::*;
#(
  parameter int RND_W         = LFSR_W,
  parameter int NUM_WORDS     = 20,
  parameter int IDX_W         = 5,
  parameter int FRESH_TIMEOUT = 31,
  parameter int AVOID_REPEAT  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [RND_W-1:0] rnd,
  input  logic             req,
  output logic             busy,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic [IDX_W-1:0] sel_index
);

  localparam int               TMO_W     = (FRESH_TIMEOUT < 1) ? 1 : $clog2(FRESH_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(FRESH_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);

  sel_state_t       state_q;
  sel_state_t       state_d;
  logic [RND_W-1:0] snap;
  logic [TMO_W-1:0] tmo;
  logic             fresh_hit;
  logic             red_start;
  logic             red_done;
  logic [IDX_W-1:0] red_rem;
  logic [IDX_W-1:0] prev_idx;
  logic             have_prev;

  // Repeat avoidance: a raw pick equal to the last accepted pick moves to the
  // next index, wrapping at NUM_WORDS-1. With a single entry there is nothing
  // to move to, so the pick is left alone.
  function automatic logic [IDX_W-1:0] avoid_repeat(input logic [IDX_W-1:0] raw,
                                                    input logic [IDX_W-1:0] prev,
                                                    input logic             prev_ok);
    logic [IDX_W-1:0] bumped;
    bumped = (raw == LAST_IDX) ? '0 : raw + 1'b1;
    if ((AVOID_REPEAT != 0) && (NUM_WORDS > 1) && prev_ok && (raw == prev)) begin
      avoid_repeat = bumped;
    end else begin
      avoid_repeat = raw;
    end
  endfunction

  serial_mod_reducer #(
    .RND_W     (RND_W),
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_reducer (
    .clock (clock),
    .reset (reset),
    .start (red_start),
    .din   (rnd),
    .done  (red_done),
    .rem   (red_rem)
  );

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    red_start = 1'b0;
    // Capture on a changed LFSR word, or give up waiting and use the current one.
    fresh_hit = (rnd != snap) || (tmo == TMO_LIMIT);
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = WAIT_FRESH;
        end
      end
      WAIT_FRESH: begin
        if (fresh_hit) begin
          red_start = 1'b1;
          state_d   = REDUCE;
        end
      end
      REDUCE: begin
        if (red_done) begin
          state_d = ADJUST;
        end
      end
      ADJUST: begin
        state_d = PRESENT;
      end
      PRESENT: begin
        // sel_valid is high for the whole of PRESENT, so ready alone completes it.
        if (sel_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Snapshot of the LFSR word at request time; only compared, never output.
  always_ff @(posedge clock) begin
    if ((state_q == IDLE) && req) begin
      snap <= rnd;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tmo       <= '0;
      sel_valid <= 1'b0;
      sel_index <= '0;
      prev_idx  <= '0;
      have_prev <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            tmo <= '0;
          end
        end
        WAIT_FRESH: begin
          if (!fresh_hit) begin
            tmo <= tmo + 1'b1;
          end
        end
        ADJUST: begin
          sel_index <= avoid_repeat(red_rem, prev_idx, have_prev);
          sel_valid <= 1'b1;
        end
        PRESENT: begin
          if (sel_ready) begin
            sel_valid <= 1'b0;
            prev_idx  <= sel_index;
            have_prev <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_word_select.sv
// Bench for random_word_select. Two instances share all inputs: dut uses the
// default repeat avoidance, dut_nr has AVOID_REPEAT=0 and must always show the
// raw remainder. Expected picks are queued when the LFSR word is driven and
// popped when a handshake occurs.
module tb_random_word_select;

  localparam int RND_W         = 13;
  localparam int NUM_WORDS     = 20;
  localparam int IDX_W         = 5;
  localparam int FRESH_TIMEOUT = 31;

  logic             clock = 1'b0;
  logic             reset;
  logic             req;
  logic             sel_ready;
  logic [RND_W-1:0] rnd;
  logic             busy;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_index;
  logic             busy_nr;
  logic             sel_valid_nr;
  logic [IDX_W-1:0] sel_index_nr;

  always #5 clock = ~clock;

  random_word_select #(
    .RND_W(RND_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W),
    .FRESH_TIMEOUT(FRESH_TIMEOUT), .AVOID_REPEAT(1)
  ) dut (
    .clock(clock), .reset(reset), .rnd(rnd), .req(req), .busy(busy),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_index(sel_index)
  );

  random_word_select #(
    .RND_W(RND_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W),
    .FRESH_TIMEOUT(FRESH_TIMEOUT), .AVOID_REPEAT(0)
  ) dut_nr (
    .clock(clock), .reset(reset), .rnd(rnd), .req(req), .busy(busy_nr),
    .sel_valid(sel_valid_nr), .sel_ready(sel_ready), .sel_index(sel_index_nr)
  );

  typedef struct {
    int unsigned adj;
    int unsigned raw;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned m_prev = 0;
  bit          m_have = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, want);
    end
  endtask

  // Reference model of one pick for the value the DUT will capture.
  task automatic push_expected(input logic [RND_W-1:0] cap);
    exp_t e;
    e.raw = int'(cap) % NUM_WORDS;
    e.adj = e.raw;
    if (m_have && (e.raw == m_prev)) e.adj = (e.raw + 1) % NUM_WORDS;
    sb_q.push_back(e);
  endtask

  // Scoreboard side: every accepted pick must match the head of the queue.
  always @(negedge clock) begin
    if (!reset && sel_valid && sel_ready) begin
      if (sb_q.size() == 0) begin
        chk("pick_unexpected", {31'd0, sel_valid}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pick_idx", {27'd0, sel_index}, mon_e.adj);
        chk("pick_idx_norepeat_off", {27'd0, sel_index_nr}, mon_e.raw);
        chk("pick_valid_norepeat_off", {31'd0, sel_valid_nr}, 32'd1);
        m_prev = mon_e.adj;
        m_have = 1'b1;
      end
    end
  end

  // Counts edges until sel_valid is seen, bounded at 100.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clock); #1;
      req = 1'b0;
      n++;
    end while (!sel_valid && n < 100);
  endtask

  task automatic pick(input logic [RND_W-1:0] new_rnd, input bit use_timeout,
                      input int hold, input bit req_in_present, input string tag);
    int               n;
    int unsigned      want_idx;
    logic [RND_W-1:0] cap;
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    req = 1'b1;
    if (use_timeout) begin
      cap = rnd;
      push_expected(cap);
      wait_valid(n);
      chk({tag, "_timeout_latency"}, n, FRESH_TIMEOUT + 16);
    end else begin
      @(posedge clock); #1;
      req = 1'b0;
      chk({tag, "_wait_busy"}, {31'd0, busy}, 32'd1);
      @(posedge clock); #1;
      rnd = new_rnd;
      cap = new_rnd;
      push_expected(cap);
      wait_valid(n);
      chk({tag, "_latency"}, n, RND_W + 2);
    end
    want_idx = (sb_q.size() > 0) ? sb_q[0].adj : 0;
    if (req_in_present) req = 1'b1;
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_valid"}, {31'd0, sel_valid}, 32'd1);
      chk({tag, "_hold_idx"}, {27'd0, sel_index}, want_idx);
      @(posedge clock); #1;
    end
    sel_ready = 1'b1;
    @(posedge clock); #1;
    sel_ready = 1'b0;
    req       = 1'b0;
    chk({tag, "_released_valid"}, {31'd0, sel_valid}, 32'd0);
    chk({tag, "_released_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_kept_idx"}, {27'd0, sel_index}, want_idx);
  endtask

  initial begin
    int seen;
    reset     = 1'b1;
    req       = 1'b0;
    sel_ready = 1'b0;
    rnd       = 13'h00F;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid", {31'd0, sel_valid}, 32'd0);
    chk("reset_idx", {27'd0, sel_index}, 32'd0);
    chk("reset_busy_norepeat_off", {31'd0, busy_nr}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    pick(13'h1234, 1'b0, 0, 1'b0, "t1_4660");
    pick(13'h1FFF, 1'b0, 10, 1'b0, "t2_8191");
    pick(13'd31, 1'b0, 0, 1'b0, "t3_bump");
    pick(13'd19, 1'b0, 0, 1'b0, "t4_prep");
    pick(13'd39, 1'b0, 2, 1'b0, "t4_wrap");

    rnd = 13'd15;
    @(posedge clock); #1;
    pick(13'd15, 1'b1, 0, 1'b0, "t5_timeout");

    // Abort a pick in the middle of the reduction.
    req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    @(posedge clock); #1;
    rnd = 13'd100;
    repeat (6) @(posedge clock);
    #1;
    chk("t6_reduce_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset  = 1'b0;
    m_have = 1'b0;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_valid", {31'd0, sel_valid}, 32'd0);
    chk("t6_rst_idx", {27'd0, sel_index}, 32'd0);
    seen = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (sel_valid || busy) seen++;
    end
    chk("t6_no_partial", seen, 32'd0);

    // 35 mod 20 = 15 equals the pre-reset pick; no bump since history was cleared.
    pick(13'd35, 1'b0, 3, 1'b1, "t6_after_rst");
    seen = 0;
    repeat (60) begin
      @(posedge clock); #1;
      if (sel_valid || busy) seen++;
    end
    chk("t6_no_second_pick", seen, 32'd0);
    chk("sb_leftover", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
